adder_share_arb: RTL and testbench



---
 rtl/adder_share_arb.sv | 111 +++++++++++
 tb/tb_adder_share_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one 32-bit combinational adder between two requesters.
// Define ADDER_ARB_CARRY_EN to add the registered unsigned carry-out port resp_carry.

module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    assign sum = a + b;
endmodule

module adder_share_arb #(
    parameter int PRIORITY_INIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        resp0_valid,
    output logic        resp1_valid,
    input  logic        resp0_ready,
    input  logic        resp1_ready,
    output logic [31:0] resp_data,
`ifdef ADDER_ARB_CARRY_EN
    output logic        resp_carry,
`endif
    output logic [1:0]  dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; a
    // requester holds valid and operands stable until ready, and ready never rises without valid.

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state;
    logic        owner;
    logic        prio;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] sum;
    logic        grant0;
    logic        grant1;
    logic        resp_owner_ready;

    adder u_adder (
        .a   (op_a),
        .b   (op_b),
        .sum (sum)
    );

    assign grant0 = req0_valid && (!req1_valid || (prio == 1'b0));
    assign grant1 = req1_valid && (!req0_valid || (prio == 1'b1));

    assign req0_ready  = (state == IDLE) && grant0;
    assign req1_ready  = (state == IDLE) && grant1;
    assign resp0_valid = (state == RESP) && (owner == 1'b0);
    assign resp1_valid = (state == RESP) && (owner == 1'b1);
    assign dbg_state   = state;

    assign resp_owner_ready = owner ? resp1_ready : resp0_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            prio      <= 1'(PRIORITY_INIT);
            op_a      <= '0;
            op_b      <= '0;
            resp_data <= '0;
`ifdef ADDER_ARB_CARRY_EN
            resp_carry <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready) begin
                        op_a  <= req0_a;
                        op_b  <= req0_b;
                        owner <= 1'b0;
                        state <= ISSUE;
                    end else if (req1_ready) begin
                        op_a  <= req1_a;
                        op_b  <= req1_b;
                        owner <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    resp_data <= sum;
`ifdef ADDER_ARB_CARRY_EN
                    // An unsigned sum wrapped exactly when it is smaller than an operand.
                    resp_carry <= (sum < op_a);
`endif
                    state <= RESP;
                end
                RESP: begin
                    if (resp_owner_ready) begin
                        prio  <= ~owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb: directed plan steps plus randomized traffic
// checked against an arithmetic/priority reference model.

module tb_adder_share_arb;
    localparam int PRIORITY_INIT = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready, resp1_ready;
    logic [31:0] resp_data;
`ifdef ADDER_ARB_CARRY_EN
    logic        resp_carry;
`endif
    logic [1:0]  dbg_state;

    adder_share_arb #(.PRIORITY_INIT(PRIORITY_INIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req1_valid  (req1_valid),
        .req0_ready  (req0_ready),
        .req1_ready  (req1_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .resp0_valid (resp0_valid),
        .resp1_valid (resp1_valid),
        .resp0_ready (resp0_ready),
        .resp1_ready (resp1_ready),
        .resp_data   (resp_data),
`ifdef ADDER_ARB_CARRY_EN
        .resp_carry  (resp_carry),
`endif
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Pending requests as seen by the requesters, and the model's priority holder.
    bit          pv[2];
    logic [31:0] pa[2];
    logic [31:0] pb[2];
    bit          m_prio;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req0_valid = pv[0];
        req0_a     = pa[0];
        req0_b     = pb[0];
        req1_valid = pv[1];
        req1_a     = pa[1];
        req1_b     = pb[1];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        pv[0]       = 1'b0;
        pv[1]       = 1'b0;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        drive();
        step();
        step();
        reset  = 1'b0;
        m_prio = 1'(PRIORITY_INIT);
        #1;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_resp0_valid", 32'(resp0_valid), 32'd0);
        check("rst_resp1_valid", 32'(resp1_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
`ifdef ADDER_ARB_CARRY_EN
        check("rst_resp_carry", 32'(resp_carry), 32'd0);
`endif
    endtask

    // One full operation starting in an idle cycle; the loser keeps its request pending.
    task automatic transact(input int stall);
        int          w;
        logic [32:0] full;
        drive();
        #1;
        if (pv[0] && pv[1]) w = int'(m_prio);
        else                w = pv[0] ? 0 : 1;
        full = {1'b0, pa[w]} + {1'b0, pb[w]};
        check("grant_req0_ready", 32'(req0_ready), 32'(w == 0));
        check("grant_req1_ready", 32'(req1_ready), 32'(w == 1));

        step();
        pv[w] = 1'b0;
        pa[w] = $urandom;
        pb[w] = $urandom;
        drive();
        #1;
        check("issue_req0_ready", 32'(req0_ready), 32'd0);
        check("issue_req1_ready", 32'(req1_ready), 32'd0);
        check("issue_resp0_valid", 32'(resp0_valid), 32'd0);
        check("issue_resp1_valid", 32'(resp1_valid), 32'd0);

        for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin
                step();
                drive();
                #1;
            end else begin
                step();
            end
            check("resp0_valid", 32'(resp0_valid), 32'(w == 0));
            check("resp1_valid", 32'(resp1_valid), 32'(w == 1));
            check("resp_data", resp_data, full[31:0]);
`ifdef ADDER_ARB_CARRY_EN
            check("resp_carry", 32'(resp_carry), 32'(full[32]));
`endif
            check("resp_req0_ready", 32'(req0_ready), 32'd0);
            check("resp_req1_ready", 32'(req1_ready), 32'd0);
        end

        if (w == 1) resp1_ready = 1'b1;
        else        resp0_ready = 1'b1;
        #1;
        step();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        #1;
        check("done_resp0_valid", 32'(resp0_valid), 32'd0);
        check("done_resp1_valid", 32'(resp1_valid), 32'd0);
        m_prio = (w == 0);
    endtask

    initial begin
        // Single requester, then the same requester again while priority points away.
        do_reset();
        pv[0] = 1'b1; pa[0] = 32'd1000; pb[0] = 32'd10;
        transact(0);
        pv[0] = 1'b1; pa[0] = 32'd3; pb[0] = 32'd4;
        transact(0);

        // Contention: req0 first, then req1, then a renewed req0 waits its turn.
        do_reset();
        pv[0] = 1'b1; pa[0] = 32'd0; pb[0] = 32'd10;
        pv[1] = 1'b1; pa[1] = 32'd5; pb[1] = 32'd7;
        transact(0);
        pv[0] = 1'b1; pa[0] = 32'd0; pb[0] = 32'd10;
        transact(0);
        transact(0);

        // Wrap-around boundaries.
        pv[1] = 1'b1; pa[1] = 32'hFFFF_FFFF; pb[1] = 32'd1;
        transact(0);
        pv[0] = 1'b1; pa[0] = 32'h7FFF_FFFF; pb[0] = 32'd1;
        transact(0);

        // Backpressure: req1 owns the adder for 5 stalled cycles while req0 waits.
        do_reset();
        m_prio = 1'b1;
        pv[1] = 1'b1; pa[1] = 32'd123; pb[1] = 32'd456;
        transact(0);
        pv[0] = 1'b1; pa[0] = 32'd11; pb[0] = 32'd22;
        pv[1] = 1'b1; pa[1] = 32'hDEAD_0000; pb[1] = 32'h0000_BEEF;
        m_prio = 1'b0;
        transact(0);
        pv[0] = 1'b1; pa[0] = 32'd77; pb[0] = 32'd88;
        transact(5);
        transact(0);

        // Reset while the operation is in ISSUE drops it silently.
        do_reset();
        pv[0] = 1'b1; pa[0] = 32'd40; pb[0] = 32'd2;
        drive();
        #1;
        check("pre_rst_req0_ready", 32'(req0_ready), 32'd1);
        step();
        reset = 1'b1;
        pv[0] = 1'b0;
        drive();
        step();
        reset  = 1'b0;
        m_prio = 1'(PRIORITY_INIT);
        #1;
        check("midrst_resp0_valid", 32'(resp0_valid), 32'd0);
        check("midrst_resp1_valid", 32'(resp1_valid), 32'd0);
        check("midrst_req0_ready", 32'(req0_ready), 32'd0);
        check("midrst_req1_ready", 32'(req1_ready), 32'd0);
        check("midrst_resp_data", resp_data, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("dropped_resp0_valid", 32'(resp0_valid), 32'd0);
        end
        pv[1] = 1'b1; pa[1] = 32'd900; pb[1] = 32'd99;
        transact(0);

        // Randomized traffic with occasional wrap-prone operands and stalls.
        for (int it = 0; it < 60; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && ($urandom_range(0, 2) != 0)) begin
                    pv[r] = 1'b1;
                    pa[r] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                    pb[r] = $urandom;
                end
            end
            if (!pv[0] && !pv[1]) begin
                pv[it % 2] = 1'b1;
                pa[it % 2] = $urandom;
                pb[it % 2] = $urandom;
            end
            transact($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
